// File: rtl/neuron_pkg.sv
// Purpose: shared FSM encoding and default widths for the neuron accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuron_pkg;

    localparam int DEF_DW   = 24;  // data / accumulator width
    localparam int DEF_WW   = 16;  // weight width
    localparam int DEF_FRAC = 8;   // fractional bits of the weight
    localparam int DEF_CW   = 8;   // term-count width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_step.sv
// Purpose: one multiply-accumulate step, y = x + ((a*b) >>> FRAC) truncated to DW.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a (signed activation), b (signed weight), x (running sum), y (next sum).
module mac_step
    import neuron_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int WW   = DEF_WW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [WW-1:0] b,
    input  logic        [DW-1:0] x,
    output logic        [DW-1:0] y
);

    logic signed [DW+WW-1:0] prod;
    logic        [DW-1:0]    scaled;

    // Full-precision signed product, then arithmetic shift drops the weight's
    // fractional bits; the high bits are discarded and the add wraps.
    assign prod   = a * b;
    assign scaled = DW'(prod >>> FRAC);
    assign y      = x + scaled;

endmodule

// File: rtl/neuron_accumulator.sv
// Purpose: evaluates one neuron: acc = bias + sum(A*b >> FRAC), optional ReLU.
// Latency: out_valid rises 2 cycles after the final term is accepted.
// Backpressure: stalls on in_valid low; holds result in DONE until out_ready.
// Ports: clk/rst (async active-high); start/mode/len/bias0/bias1/relu_en
//        sampled on start in IDLE; in_valid/in_ready term handshake with a0/a1/b;
//        out_valid/out_ready result handshake with out; busy = not IDLE.
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int WW   = DEF_WW,
    parameter int FRAC = DEF_FRAC,
    parameter int CW   = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] len,
    input  logic [DW-1:0] bias0,
    input  logic [DW-1:0] bias1,
    input  logic          relu_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] a1,
    input  logic [WW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q,   acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] len_q,   len_d;
    logic          mode_q,  mode_d;
    logic          relu_q,  relu_d;
    logic [DW-1:0] out_q,   out_d;

    logic [DW-1:0] term_a;
    logic [DW-1:0] acc_next;
    logic          accept;
    logic          last_term;

    assign term_a = mode_q ? a1 : a0;
    assign accept = in_valid && in_ready;

    mac_step #(
        .DW   (DW),
        .WW   (WW),
        .FRAC (FRAC)
    ) u_mac (
        .a (term_a),
        .b (b),
        .x (acc_q),
        .y (acc_next)
    );

    // Leave ACCUM on the same edge that takes the final term so the result
    // appears two cycles later; len = 0 leaves after one cycle in ACCUM.
    assign last_term = (count_q == len_q) ||
                       (accept && ((count_q + CW'(1)) == len_q));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        relu_d  = relu_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = len;
                    relu_d  = relu_en;
                    acc_d   = mode ? bias1 : bias0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_next;
                    count_d = count_q + CW'(1);
                end
                if (last_term) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                out_d   = (relu_q && acc_q[DW-1]) ? '0 : acc_q;
                state_d = DONE;
            end
            DONE: begin
                // start here is deliberately dropped, even on the handshake cycle
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            relu_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
        end
    end

    // Status outputs decode straight from flops, so reset clears them at once.
    assign in_ready  = (state_q == ACCUM) && (count_q < len_q);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;

endmodule
